// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory access unit.
//   DEF_DATA_W / DEF_ADDR_W : default memory data and address widths
//   WIDE_W                  : width of a wide (two-byte) access
//   mau_state_e             : sequencer states
//   is_byte_phase()         : true while the unit is driving a memory byte
package mem_access_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_ADDR_W = 8;
  localparam int WIDE_W     = 2 * DEF_DATA_W;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BYTE0 = 2'd1,
    BYTE1 = 2'd2,
    RESP  = 2'd3
  } mau_state_e;

  function automatic logic is_byte_phase(input mau_state_e s);
    return (s == BYTE0) || (s == BYTE1);
  endfunction

endpackage

// File: rtl/mem_access_unit.sv
// Initiator for the 8-bit single-port data memory. Accepts byte or 16-bit
// little-endian load/store requests over valid/ready, splits a wide access
// into two sequential byte accesses and returns a one-cycle response pulse.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   req_valid/req_ready   request handshake (ready only in IDLE, out of reset)
//   req_we, req_wide      store / 16-bit access selects
//   req_addr, req_wdata   byte address (low byte for wide), store data
//   rsp_valid, rsp_rdata  completion pulse, zero-extended load data
//   mem_we, mem_addr,     memory port; mem_out is combinational from mem_addr
//   mem_in, mem_out
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | ready for a request; memory port holds last driven address/data
// BYTE0 | access low byte at addr
// BYTE1 | access high byte at addr+1 (wraps), wide accesses only
// RESP  | rsp_valid pulse with collected read data
module mem_access_unit
  import mem_access_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic                  req_wide,
  input  logic [ADDR_W-1:0]     req_addr,
  input  logic [2*DATA_W-1:0]   req_wdata,
  output logic                  rsp_valid,
  output logic [2*DATA_W-1:0]   rsp_rdata,
  output logic                  mem_we,
  output logic [ADDR_W-1:0]     mem_addr,
  output logic [DATA_W-1:0]     mem_in,
  input  logic [DATA_W-1:0]     mem_out
);

  localparam int WORD_W = 2 * DATA_W;

  mau_state_e          state_q, state_d;
  logic                we_q, we_d;
  logic                wide_q, wide_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic [WORD_W-1:0]   rdata_q, rdata_d;
  // Last values driven onto the memory port, held through IDLE/RESP.
  logic [ADDR_W-1:0]   drv_addr_q, drv_addr_d;
  logic [DATA_W-1:0]   drv_in_q, drv_in_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      we_q       <= 1'b0;
      wide_q     <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rdata_q    <= '0;
      drv_addr_q <= '0;
      drv_in_q   <= '0;
    end else begin
      state_q    <= state_d;
      we_q       <= we_d;
      wide_q     <= wide_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      drv_addr_q <= drv_addr_d;
      drv_in_q   <= drv_in_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    we_d       = we_q;
    wide_d     = wide_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    drv_addr_d = drv_addr_q;
    drv_in_d   = drv_in_q;

    case (state_q)
      IDLE: begin
        if (req_valid && req_ready) begin
          we_d    = req_we;
          wide_d  = req_wide;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          rdata_d = '0;
          state_d = BYTE0;
        end
      end
      BYTE0: begin
        drv_addr_d = addr_q;
        drv_in_d   = wdata_q[DATA_W-1:0];
        if (!we_q) begin
          rdata_d[DATA_W-1:0] = mem_out;
        end
        state_d = wide_q ? BYTE1 : RESP;
      end
      BYTE1: begin
        // Address arithmetic wraps modulo 2^ADDR_W.
        drv_addr_d = addr_q + ADDR_W'(1);
        drv_in_d   = wdata_q[WORD_W-1:DATA_W];
        if (!we_q) begin
          rdata_d[WORD_W-1:DATA_W] = mem_out;
        end
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Every output is forced quiet while rst_n is low so an access aborted by
  // reset cannot complete its current write or raise a response.
  assign req_ready = rst_n && (state_q == IDLE);
  assign mem_we    = rst_n && we_q && is_byte_phase(state_q);
  assign mem_addr  = rst_n ? drv_addr_d : '0;
  assign mem_in    = rst_n ? drv_in_d : '0;
  assign rsp_valid = rst_n && (state_q == RESP);
  assign rsp_rdata = rst_n ? rdata_q : '0;

endmodule

// File: tb/tb_mem_access_unit.sv
module tb_mem_access_unit;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic        req_wide;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        rsp_valid;
  logic [15:0] rsp_rdata;
  logic        mem_we;
  logic [7:0]  mem_addr;
  logic [7:0]  mem_in;
  logic [7:0]  mem_out;

  mem_access_unit dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_wide  (req_wide),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_in    (mem_in),
    .mem_out   (mem_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256x8 target memory: synchronous write, combinational read.
  logic [7:0] mem [256];
  initial for (int i = 0; i < 256; i++) mem[i] = 8'h00;
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_in;
  assign mem_out = mem[mem_addr];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  typedef struct { logic [15:0] rd; int cyc; } rsp_t;
  typedef struct { logic [7:0] a; logic [7:0] d; int cyc; } wr_t;
  rsp_t rsp_q[$];
  wr_t  wr_q[$];
  rsp_t mon_r;
  wr_t  mon_w;

  // Output monitor: every response and every memory write must match the
  // next scoreboard entry, including the cycle it was expected in.
  always @(negedge clk) begin
    if (rsp_valid) begin
      if (rsp_q.size() == 0) chk("spurious_rsp", rsp_valid, 1'b0);
      else begin
        mon_r = rsp_q.pop_front();
        chk("rsp_rdata", rsp_rdata, mon_r.rd);
        chk("rsp_cycle", cyc, mon_r.cyc);
      end
    end
    if (mem_we) begin
      if (wr_q.size() == 0) chk("spurious_we", mem_we, 1'b0);
      else begin
        mon_w = wr_q.pop_front();
        chk("wr_addr", mem_addr, mon_w.a);
        chk("wr_data", mem_in, mon_w.d);
        chk("wr_cycle", cyc, mon_w.cyc);
      end
    end
  end

  // Called at a negedge; returns at the negedge after the accept edge with
  // req_valid still high. abort_b1 marks a wide store that reset will cut
  // short after its first byte.
  task automatic issue(input logic we, input logic wide, input logic [7:0] addr,
                       input logic [15:0] wd, input logic [15:0] exp_rd,
                       input bit abort_b1, output int acc_cyc);
    int t = 0;
    req_valid = 1'b1;
    req_we    = we;
    req_wide  = wide;
    req_addr  = addr;
    req_wdata = wd;
    while (!req_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("accept_timeout", req_ready, 1'b1);
      req_valid = 1'b0;
      acc_cyc = -1;
      return;
    end
    acc_cyc = cyc + 1;
    if (!abort_b1) rsp_q.push_back('{rd: exp_rd, cyc: cyc + 1 + (wide ? 2 : 1)});
    if (we) begin
      wr_q.push_back('{a: addr, d: wd[7:0], cyc: cyc + 1});
      if (wide && !abort_b1) wr_q.push_back('{a: 8'(addr + 8'd1), d: wd[15:8], cyc: cyc + 2});
    end
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  int a1, a2;

  initial begin
    rst_n     = 1'b0;
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_wide  = 1'b1;
    req_addr  = 8'h55;
    req_wdata = 16'hFFFF;

    // Reset held two edges with a request pending.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", req_ready, 1'b0);
    chk("rst_mem_we", mem_we, 1'b0);
    chk("rst_mem_addr", mem_addr, 8'h00);
    chk("rst_mem_in", mem_in, 8'h00);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    rst_n = 1'b1;
    req_valid = 1'b0;
    #1;
    chk("ready_after_rst", req_ready, 1'b1);
    @(negedge clk);

    // Byte store then byte load.
    issue(1'b1, 1'b0, 8'h10, 16'h003C, 16'h0000, 1'b0, a1);
    idle(2);
    chk("idle_hold_addr", mem_addr, 8'h10);
    chk("idle_hold_in", mem_in, 8'h3C);
    chk("mem_10", mem[8'h10], 8'h3C);
    issue(1'b0, 1'b0, 8'h10, 16'h0000, 16'h003C, 1'b0, a1);
    idle(3);

    // Wide store wrapping past 0xFF, then wide load back.
    issue(1'b1, 1'b1, 8'hFF, 16'hBEEF, 16'h0000, 1'b0, a1);
    idle(3);
    chk("mem_ff", mem[8'hFF], 8'hEF);
    chk("mem_00", mem[8'h00], 8'hBE);
    issue(1'b0, 1'b1, 8'hFF, 16'h0000, 16'hBEEF, 1'b0, a1);
    idle(4);

    // Back-to-back with req_valid held high across requests.
    issue(1'b1, 1'b0, 8'h20, 16'h005A, 16'h0000, 1'b0, a1);
    issue(1'b1, 1'b0, 8'h21, 16'h00A5, 16'h0000, 1'b0, a2);
    idle(3);
    issue(1'b0, 1'b0, 8'h20, 16'h0000, 16'h005A, 1'b0, a1);
    issue(1'b0, 1'b0, 8'h21, 16'h0000, 16'h00A5, 1'b0, a2);
    chk("b2b_spacing", a2 - a1, 3);
    idle(3);
    chk("b2b_drained", rsp_q.size(), 0);

    // Reset while a wide store is in BYTE1.
    issue(1'b1, 1'b1, 8'h40, 16'h1234, 16'h0000, 1'b1, a1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    chk("abort_mem_we", mem_we, 1'b0);
    chk("abort_ready", req_ready, 1'b0);
    @(negedge clk);
    chk("abort_rsp_valid", rsp_valid, 1'b0);
    chk("abort_rsp_rdata", rsp_rdata, 16'h0000);
    chk("abort_mem_addr", mem_addr, 8'h00);
    rst_n = 1'b1;
    #1;
    chk("abort_idle", req_ready, 1'b1);
    chk("abort_mem_40", mem[8'h40], 8'h34);
    chk("abort_mem_41", mem[8'h41], 8'h00);
    @(negedge clk);
    idle(4);

    // Load from an address never written.
    issue(1'b0, 1'b0, 8'h80, 16'h0000, 16'h0000, 1'b0, a1);
    idle(4);

    chk("rsp_q_empty", rsp_q.size(), 0);
    chk("wr_q_empty", wr_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the 8-bit single-port data memory: takes load/store requests from the CPU datapath over a valid/ready handshake and drives the memory port (mem_we, mem_addr, mem_in), reading mem_out.
- Supports byte and 16-bit little-endian ("wide") accesses. A wide access is split into two sequential byte accesses.
- Returns a single-cycle response pulse carrying read data or a write acknowledge.

Parameters:
- DATA_W, 8, memory data width; a wide access is 2*DATA_W.
- ADDR_W, 8, memory address width; address arithmetic wraps modulo 2^ADDR_W.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  synchronous active-low reset.
- req_valid  input  1  request present.
- req_ready  output  1  unit can accept; high only in IDLE with rst_n high.
- req_we  input  1  1 = store, 0 = load.
- req_wide  input  1  1 = 16-bit access, 0 = byte.
- req_addr  input  ADDR_W  byte address (low byte for wide).
- req_wdata  input  2*DATA_W  store data; byte access uses [DATA_W-1:0].
- rsp_valid  output  1  one-cycle completion pulse.
- rsp_rdata  output  2*DATA_W  load data, zero-extended for byte; 0 for stores.
- mem_we  output  1  memory write enable.
- mem_addr  output  ADDR_W  memory address.
- mem_in  output  DATA_W  memory write data.
- mem_out  input  DATA_W  memory read data, combinational from mem_addr.

Behaviour:
- States: IDLE, BYTE0, BYTE1, RESP.
- Handshake and latching:
  - A request is accepted at a rising edge where req_valid && req_ready.
  - On acceptance, latch we, wide, addr and wdata, clear the rdata register, and go to BYTE0.
  - Request inputs are ignored outside acceptance.
- BYTE0:
  - mem_addr = latched addr; mem_in = wdata[DATA_W-1:0]; mem_we = latched we.
  - Load: capture mem_out into rdata[DATA_W-1:0] at the closing edge.
  - Next state: BYTE1 if wide, else RESP.
- BYTE1:
  - mem_addr = latched addr + 1, truncated to ADDR_W, so 0xFF wraps to 0x00.
  - mem_in = wdata[2*DATA_W-1:DATA_W]; mem_we = latched we.
  - Load: capture mem_out into rdata[2*DATA_W-1:DATA_W].
  - Next state: RESP.
- RESP:
  - rsp_valid = 1 for exactly one cycle; rsp_rdata = rdata (0 for stores); mem_we = 0.
  - Next state: IDLE.
- IDLE:
  - req_ready = 1, rsp_valid = 0, mem_we = 0.
  - mem_addr and mem_in hold their last driven values; 0 after reset.
- Latency, counted from the accept edge:
  - Byte access: rsp_valid in the 2nd following cycle (accept, BYTE0, RESP).
  - Wide access: rsp_valid in the 3rd following cycle.
  - Throughput: one byte op per 3 cycles, one wide op per 4 cycles. No acceptance in RESP.
- mem_we is high exactly 1 cycle for a byte store and 2 cycles for a wide store, and never otherwise.
- Held request: req_valid held through a busy period is accepted only at the next IDLE edge. The access is performed exactly once per acceptance.
- Reset (rst_n low at an edge, any state including mid-operation):
  - Go to IDLE; clear all latched fields and rdata.
  - Outputs: mem_we = 0, mem_addr = 0, mem_in = 0, rsp_valid = 0, rsp_rdata = 0.
  - req_ready = 0 while rst_n is low.
  - An aborted access produces no rsp_valid.
  - A byte already written in BYTE0 remains written; BYTE1 is not performed.
- No misalignment restriction; wide accesses at any address are legal.

Decomposition:
- Package mem_access_pkg:
  - state enum (IDLE, BYTE0, BYTE1, RESP);
  - DATA_W and ADDR_W default constants;
  - WIDE_W = 2*DATA_W.
- No sub-module: a single FSM plus datapath registers. The bench instantiates the existing 256x8 memory as the target.

Test Plan:
- Reset: rst_n low 2 cycles with req_valid = 1 -> req_ready = 0, all outputs 0, no mem_we; req_ready = 1 the first cycle after release.
- Byte store 0x3C to addr 0x10, then byte load 0x10 -> mem_we high 1 cycle with mem_addr = 0x10, mem_in = 0x3C; load rsp_valid 2 cycles after accept with rsp_rdata = 0x003C.
- Wide store 0xBEEF at addr 0xFF -> writes mem[0xFF] = 0xEF then mem[0x00] = 0xBE on consecutive cycles; wide load at 0xFF returns rsp_rdata = 0xBEEF 3 cycles after accept.
- Back-to-back: req_valid held high with a byte load to 0x20 followed by a byte load to 0x21 -> second accepted only in IDLE 3 cycles after the first; exactly two rsp_valid pulses; correct data each.
- Reset during BYTE1 of a wide store 0x1234 at 0x40 -> mem[0x40] = 0x34, mem[0x41] unchanged (0x00), no rsp_valid, unit back in IDLE.
- Byte load from unwritten addr 0x80 after reset -> rsp_rdata = 0x0000; no mem_we pulse during the load.
